ram_dumper: RTL

Read-back engine for the 16-byte program RAM, the counterpart of the byte-loading programmer. While `dumping` is high it takes ownership of the CPU bus and control word. For each address it loads the MAR, enables the RAM onto the bus, and captures the byte. It then presents the byte on dedicated pins with a valid/next handshake, so an external host can verify a loaded program.

---
 rtl/ram_dumper_pkg.sv | 30 +++
 rtl/ram_dumper.sv | 98 +++++++++
 2 files changed

// File: rtl/ram_dumper_pkg.sv
// Shared definitions for the RAM read-back engine: control-word bit indices,
// the idle control word and the dumper state encoding.
package ram_dumper_pkg;

    localparam int BUS_WIDTH  = 8;
    localparam int CTRL_WIDTH = 15;

    // Active-low control bits the dumper pulls; every other bit stays at idle.
    localparam int SIG_LMA_N = 11;
    localparam int SIG_CE_N  = 9;

    localparam logic [CTRL_WIDTH-1:0] CTRL_IDLE = 15'h0FE3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_READ    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } dump_state_e;

    function automatic logic [CTRL_WIDTH-1:0] ctrl_word(input dump_state_e st);
        logic [CTRL_WIDTH-1:0] w;
        w = CTRL_IDLE;
        if (st == ST_ADDR) w[SIG_LMA_N] = 1'b0;
        if (st == ST_READ) w[SIG_CE_N]  = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/ram_dumper.sv
// Reads the program RAM back one byte at a time: loads the MAR, enables the RAM
// onto the bus, captures the byte and hands it to a host via valid/next.
module ram_dumper
    import ram_dumper_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int LAST_ADDR  = 15
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  dumping,
    input  logic                  next_byte,
    inout  wire  [BUS_WIDTH-1:0]  bus,
    output logic [CTRL_WIDTH-1:0] out,
    output logic [BUS_WIDTH-1:0]  data_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  data_valid,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);

    dump_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_WIDTH-1:0]  data_out_q, data_out_d;
    logic [ADDR_WIDTH-1:0] addr_out_q, addr_out_d;
    logic                  next_byte_dly_q, next_byte_dly_d;
    logic                  next_edge;

    assign next_edge = next_byte & ~next_byte_dly_q;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        data_out_d      = data_out_q;
        addr_out_d      = addr_out_q;
        next_byte_dly_d = next_byte;

        // Losing the enable abandons the dump from any active state.
        if (state_q != ST_IDLE && !dumping) begin
            state_d = ST_IDLE;
            addr_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    addr_d = '0;
                    if (dumping) state_d = ST_ADDR;
                end
                ST_ADDR: state_d = ST_READ;
                ST_READ: begin
                    data_out_d = bus;
                    addr_out_d = addr_q;
                    state_d    = ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (next_edge) begin
                        if (addr_q == LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            addr_d  = addr_q + ADDR_WIDTH'(1);
                            state_d = ST_ADDR;
                        end
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            data_out_q      <= '0;
            addr_out_q      <= '0;
            next_byte_dly_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            data_out_q      <= data_out_d;
            addr_out_q      <= addr_out_d;
            next_byte_dly_q <= next_byte_dly_d;
        end
    end

    // Moore decode: the RAM may only drive during READ, so ADDR is our sole window.
    assign bus        = (state_q == ST_ADDR) ? BUS_WIDTH'(addr_q) : {BUS_WIDTH{1'bz}};
    assign out        = ctrl_word(state_q);
    assign data_out   = data_out_q;
    assign addr_out   = addr_out_q;
    assign data_valid = (state_q == ST_PRESENT);
    assign done       = (state_q == ST_DONE);

endmodule
